// File: rtl/fifo_stream_out_skid_if.sv
// Stream-out FIFO bus: producer write side plus valid/ready downstream link.
// Optional overflow flag present only when FIFO_STREAM_OVF_EN is defined.
interface fifo_stream_out_skid_if #(
  parameter int unsigned PAYLOAD_BITS       = 32,
  parameter int unsigned NUM_BRAM_ADDR_BITS = 9
);
  logic [PAYLOAD_BITS-1:0]         wdata;
  logic                            winc;
  logic                            full;
  logic                            almost_full;
  logic [NUM_BRAM_ADDR_BITS+1:0]   level;
  logic [PAYLOAD_BITS-1:0]         dout;
  logic                            val_out;
  logic                            ready_downward;
`ifdef FIFO_STREAM_OVF_EN
  logic                            overflow;

  modport master (
    input  wdata, winc, ready_downward,
    output full, almost_full, level, dout, val_out, overflow
  );
  modport slave (
    output wdata, winc, ready_downward,
    input  full, almost_full, level, dout, val_out, overflow
  );
`else
  modport master (
    input  wdata, winc, ready_downward,
    output full, almost_full, level, dout, val_out
  );
  modport slave (
    output wdata, winc, ready_downward,
    input  full, almost_full, level, dout, val_out
  );
`endif
endinterface

// File: rtl/fifo_stream_out_skid.sv
// Stream-out FIFO: circular buffer with registered read feeding a 2-entry skid stage.
// Optional sticky overflow flag enabled by defining FIFO_STREAM_OVF_EN.
module fifo_stream_out_skid #(
  parameter int unsigned PAYLOAD_BITS       = 32,
  parameter int unsigned NUM_BRAM_ADDR_BITS = 9,
  parameter int unsigned AFULL_THRESH       = (2**NUM_BRAM_ADDR_BITS) - 4
) (
  input logic                    clk,
  input logic                    reset,
  fifo_stream_out_skid_if.master s
);
  localparam int unsigned AW    = NUM_BRAM_ADDR_BITS;
  localparam int unsigned DEPTH = 2**AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_THRESH);

  typedef enum logic [1:0] {SK_EMPTY, SK_ONE, SK_TWO} skid_state_t;

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             mem_count, mem_count_next;
  logic                    rd_inflight;
  logic [PAYLOAD_BITS-1:0] rd_data;
  logic [PAYLOAD_BITS-1:0] skid_head, skid_tail;
  skid_state_t             skid_state, skid_next;
  logic [1:0]              skid_used, skid_used_next;
  logic [2:0]              occ_after;
  logic                    val, pop, arrive, wr_ok, rd_en;
  logic [AW+1:0]           level_q;

  assign s.full        = (mem_count == DEPTH_C);
  assign s.almost_full = (mem_count >= AFULL_C);
  assign s.level       = level_q;
  assign s.val_out     = val;
  assign s.dout        = val ? skid_head : '0;

  assign wr_ok  = s.winc & ~s.full;
  assign arrive = rd_inflight;

  // Skid FSM: occupancy and transitions
  always_comb begin
    skid_next      = skid_state;
    skid_used      = '0;
    skid_used_next = '0;
    val            = (skid_state != SK_EMPTY);
    pop            = val & s.ready_downward;
    case (skid_state)
      SK_EMPTY: begin
        skid_used = 2'd0;
        if (arrive) skid_next = SK_ONE;
      end
      SK_ONE: begin
        skid_used = 2'd1;
        if (pop && !arrive)      skid_next = SK_EMPTY;
        else if (arrive && !pop) skid_next = SK_TWO;
      end
      SK_TWO: begin
        skid_used = 2'd2;
        if (pop) skid_next = SK_ONE;
      end
      default: skid_next = SK_EMPTY;
    endcase
    case (skid_next)
      SK_ONE:  skid_used_next = 2'd1;
      SK_TWO:  skid_used_next = 2'd2;
      default: skid_used_next = 2'd0;
    endcase
  end

  // A read is issued only if its result is guaranteed a free skid slot on arrival
  always_comb begin
    occ_after      = {1'b0, skid_used} - {2'b0, pop} + {2'b0, rd_inflight};
    rd_en          = (mem_count != '0) && (occ_after < 3'd2);
    mem_count_next = mem_count;
    case ({wr_ok, rd_en})
      2'b10:   mem_count_next = mem_count + 1'b1;
      2'b01:   mem_count_next = mem_count - 1'b1;
      default: mem_count_next = mem_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= s.wdata;
    if (rd_en) rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_count   <= '0;
      rd_inflight <= 1'b0;
      skid_state  <= SK_EMPTY;
      level_q     <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      mem_count   <= mem_count_next;
      rd_inflight <= rd_en;
      skid_state  <= skid_next;
      level_q     <= {1'b0, mem_count_next} + (AW+2)'(rd_en) + (AW+2)'(skid_used_next);
    end
  end

  always_ff @(posedge clk) begin
    case (skid_state)
      SK_EMPTY: if (arrive) skid_head <= rd_data;
      SK_ONE: begin
        if (arrive && pop)  skid_head <= rd_data;
        if (arrive && !pop) skid_tail <= rd_data;
      end
      SK_TWO:   if (pop) skid_head <= skid_tail;
      default: ;
    endcase
  end

`ifdef FIFO_STREAM_OVF_EN
  logic overflow_q;
  assign s.overflow = overflow_q;

  always_ff @(posedge clk) begin
    if (reset) overflow_q <= 1'b0;
    else if (s.winc && s.full) overflow_q <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_fifo_stream_out_skid.sv
// Self-checking bench for fifo_stream_out_skid: directed steps plus random traffic
// against a queue-based reference model.
module tb_fifo_stream_out_skid;
  localparam int unsigned PB    = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 2**AW;
  localparam int unsigned AFULL = DEPTH - 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  fifo_stream_out_skid_if #(.PAYLOAD_BITS(PB), .NUM_BRAM_ADDR_BITS(AW)) bus ();

  fifo_stream_out_skid #(
    .PAYLOAD_BITS(PB),
    .NUM_BRAM_ADDR_BITS(AW),
    .AFULL_THRESH(AFULL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s(bus)
  );

  always #5 clk = ~clk;

  // Reference model: memory queue, one in-flight read slot, skid queue
  logic [PB-1:0] m_mem[$];
  logic [PB-1:0] m_skid[$];
  bit            m_inf;
  logic [PB-1:0] m_inf_d;
  bit            m_ovf;
  bit            hold_prev;
  logic [PB-1:0] hold_dout;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_mem.delete();
    m_skid.delete();
    m_inf     = 0;
    hold_prev = 0;
  endtask

  // One clock: drive, compare all outputs to model at negedge, advance model at posedge
  task automatic step(input bit w, input logic [PB-1:0] d, input bit r);
    bit            mv, mpop, mfull, mrd;
    logic [PB-1:0] mdout;
    bus.winc           = w;
    bus.wdata          = d;
    bus.ready_downward = r;
    @(negedge clk);
    mv    = (m_skid.size() != 0);
    mdout = mv ? m_skid[0] : '0;
    mfull = (m_mem.size() == DEPTH);
    check("val_out", 64'(bus.val_out), 64'(mv));
    check("dout", 64'(bus.dout), 64'(mdout));
    check("full", 64'(bus.full), 64'(mfull));
    check("almost_full", 64'(bus.almost_full), 64'(m_mem.size() >= AFULL));
    check("level", 64'(bus.level), 64'(m_mem.size() + int'(m_inf) + m_skid.size()));
`ifdef FIFO_STREAM_OVF_EN
    check("overflow", 64'(bus.overflow), 64'(m_ovf));
`endif
    if (hold_prev) begin
      check("hold_val", 64'(bus.val_out), 64'd1);
      check("hold_dout", 64'(bus.dout), 64'(hold_dout));
    end
    hold_prev = mv && !r;
    hold_dout = mdout;
    mpop = mv && r;
    mrd  = (m_mem.size() != 0) && (m_skid.size() - int'(mpop) + int'(m_inf) < 2);
    @(posedge clk);
    if (mpop) void'(m_skid.pop_front());
    if (m_inf) m_skid.push_back(m_inf_d);
    m_inf = mrd;
    if (mrd) m_inf_d = m_mem.pop_front();
    if (w && !mfull) m_mem.push_back(d);
    if (w && mfull) m_ovf = 1;
    #1;
  endtask

  task automatic do_reset(input bit r);
    bus.winc           = 1'b0;
    bus.wdata          = '0;
    bus.ready_downward = r;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    m_ovf = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_cnt;
    int budget;
    bus.winc = 1'b0;
    bus.wdata = '0;
    bus.ready_downward = 1'b0;
    m_ovf = 0;
    model_clear();

    // Reset state
    do_reset(1'b0);
    check("rst_val_out", 64'(bus.val_out), 64'd0);
    check("rst_dout", 64'(bus.dout), 64'd0);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_afull", 64'(bus.almost_full), 64'd0);
    check("rst_level", 64'(bus.level), 64'd0);
`ifdef FIFO_STREAM_OVF_EN
    check("rst_overflow", 64'(bus.overflow), 64'd0);
`endif

    // Single word latency: visible two edges after the write
    step(1'b1, 16'h00A5, 1'b1);
    check("lat_level_n", 64'(bus.level), 64'd1);
    check("lat_val_n", 64'(bus.val_out), 64'd0);
    step(1'b0, '0, 1'b1);
    check("lat_val_n1", 64'(bus.val_out), 64'd0);
    step(1'b0, '0, 1'b1);
    check("lat_val_n2", 64'(bus.val_out), 64'd1);
    check("lat_dout_n2", 64'(bus.dout), 64'h00A5);
    check("lat_level_n2", 64'(bus.level), 64'd1);
    step(1'b0, '0, 1'b1);
    check("lat_val_pop", 64'(bus.val_out), 64'd0);
    check("lat_level_pop", 64'(bus.level), 64'd0);

    // Fill with downstream stalled, then one dropped write, then drain in order
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(1'b1, PB'(i), 1'b0);
      check("fill_dout", 64'(bus.dout), 64'd0);
    end
    check("fill_full", 64'(bus.full), 64'd1);
    check("fill_level", 64'(bus.level), 64'(DEPTH + 2));
    check("fill_afull", 64'(bus.almost_full), 64'd1);
    step(1'b1, 16'h00FF, 1'b0);
    check("drop_level", 64'(bus.level), 64'(DEPTH + 2));
`ifdef FIFO_STREAM_OVF_EN
    check("ovf_set", 64'(bus.overflow), 64'd1);
`endif
    for (int i = 0; i < DEPTH + 2; i++) begin
      check("drain_val", 64'(bus.val_out), 64'd1);
      check("drain_dout", 64'(bus.dout), 64'(i));
      step(1'b0, '0, 1'b1);
    end
    step(1'b0, '0, 1'b1);
    check("drain_empty_val", 64'(bus.val_out), 64'd0);
    check("drain_empty_level", 64'(bus.level), 64'd0);
`ifdef FIFO_STREAM_OVF_EN
    check("ovf_sticky", 64'(bus.overflow), 64'd1);
    do_reset(1'b0);
    check("ovf_cleared", 64'(bus.overflow), 64'd0);
`endif

    // Continuous streaming across three pointer wraps: no gaps once started
    exp_cnt = 0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      step(1'b1, PB'(i), 1'b1);
      if (exp_cnt > 0) check("stream_nogap", 64'(bus.val_out), 64'd1);
      if (bus.val_out) begin
        check("stream_dout", 64'(bus.dout), 64'(exp_cnt));
        exp_cnt++;
      end
    end
    budget = 20;
    while (exp_cnt < 3 * DEPTH && budget > 0) begin
      step(1'b0, '0, 1'b1);
      if (exp_cnt < 3 * DEPTH) check("stream_tail_nogap", 64'(bus.val_out), 64'd1);
      if (bus.val_out) begin
        check("stream_tail_dout", 64'(bus.dout), 64'(exp_cnt));
        exp_cnt++;
      end
      budget--;
    end
    check("stream_count", 64'(exp_cnt), 64'(3 * DEPTH));
    step(1'b0, '0, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      step(($urandom % 4) != 0, PB'($urandom), ($urandom % 2) != 0);
    end
    budget = 3 * DEPTH;
    while ((m_mem.size() + int'(m_inf) + m_skid.size()) != 0 && budget > 0) begin
      step(1'b0, '0, 1'b1);
      budget--;
    end
    check("rand_drained", 64'(bus.level), 64'd0);

    // Reset mid-transfer drops everything; new data follows with normal latency
    for (int i = 0; i < 10; i++) step(1'b1, PB'(16'h0100 + i), 1'b0);
    do_reset(1'b1);
    check("midrst_val", 64'(bus.val_out), 64'd0);
    check("midrst_level", 64'(bus.level), 64'd0);
    check("midrst_full", 64'(bus.full), 64'd0);
    check("midrst_dout", 64'(bus.dout), 64'd0);
    step(1'b1, 16'h003C, 1'b1);
    step(1'b0, '0, 1'b1);
    check("post_rst_val_n1", 64'(bus.val_out), 64'd0);
    step(1'b0, '0, 1'b1);
    check("post_rst_val_n2", 64'(bus.val_out), 64'd1);
    check("post_rst_dout", 64'(bus.dout), 64'h003C);
    step(1'b0, '0, 1'b1);
    check("post_rst_empty", 64'(bus.val_out), 64'd0);
    step(1'b0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
